multi_cycle_adder: RTL and testbench

- Parametrised multi-cycle add/subtract unit built from a DIGIT-bit full-adder ripple slice reused over WIDTH/DIGIT cycles, with a registered carry between slices.
- Accepts operands on a start pulse. Reports busy while computing. Pulses done with sum, carry-out and signed overflow.
- Serves as the arithmetic core for the 8-bit ALU datapath and wider follow-ons, where area matters more than latency.

---
 rtl/multi_cycle_adder_if.sv | 20 ++
 rtl/multi_cycle_adder.sv | 100 ++++++++++
 tb/tb_multi_cycle_adder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_adder_if.sv
// Operand/result bundle for multi_cycle_adder; master issues requests, slave computes.
interface multi_cycle_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (output start, sub, a, b, cin,
                   input  sum, cout, overflow, busy, done);
   modport slave  (input  start, sub, a, b, cin,
                   output sum, cout, overflow, busy, done);
endinterface

// File: rtl/multi_cycle_adder.sv
// Digit-serial add/subtract: one DIGIT-bit ripple slice reused WIDTH/DIGIT times,
// carry held in a register between slices.
module multi_cycle_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input logic                clk,
   input logic                rst_n,
   multi_cycle_adder_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_param
      $error("multi_cycle_adder: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [DIGIT:0]   slice;
   logic             msb_cin;

   always_comb begin
      // operands shift right each step, so the live digit is always the low slice
      slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d = RUN;
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub | bus.cin;
               cnt_d   = '0;
               psum_d  = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            psum_d  = WIDTH'({slice[DIGIT-1:0], psum_q} >> DIGIT);
            carry_d = slice[DIGIT];
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               sum_d   = psum_d;
               cout_d  = slice[DIGIT];
               ovf_d   = msb_cin ^ slice[DIGIT];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed and random checks of multi_cycle_adder at DIGIT = 8, 2 and 1 (WIDTH = 8).
module tb_multi_cycle_adder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, sub, cin;
   logic [7:0] a, b;

   always #5 clk = ~clk;

   multi_cycle_adder_if #(.WIDTH(8)) i8 ();
   multi_cycle_adder_if #(.WIDTH(8)) i2 ();
   multi_cycle_adder_if #(.WIDTH(8)) i1 ();

   assign i8.start = start; assign i8.sub = sub; assign i8.cin = cin; assign i8.a = a; assign i8.b = b;
   assign i2.start = start; assign i2.sub = sub; assign i2.cin = cin; assign i2.a = a; assign i2.b = b;
   assign i1.start = start; assign i1.sub = sub; assign i1.cin = cin; assign i1.a = a; assign i1.b = b;

   multi_cycle_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
   multi_cycle_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
   multi_cycle_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

   // index 0: DIGIT=8, 1: DIGIT=2, 2: DIGIT=1
   logic [2:0]      busy_w, done_w, cout_w, ovf_w;
   logic [2:0][7:0] sum_w;
   assign busy_w = {i1.busy, i2.busy, i8.busy};
   assign done_w = {i1.done, i2.done, i8.done};
   assign cout_w = {i1.cout, i2.cout, i8.cout};
   assign ovf_w  = {i1.overflow, i2.overflow, i8.overflow};
   assign sum_w  = {i1.sum, i2.sum, i8.sum};

   int         n_vec = 0;
   int         n_err = 0;
   int         ns [3] = '{1, 4, 8};
   logic [7:0] prev_sum [3];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One start pulse, then watch every build for busy length, done timing and result.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic ev);
      int         bcnt [3];
      int         didx [3];
      int         dcnt [3];
      logic [7:0] rs [3];
      logic       rc [3];
      logic       rv [3];
      a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
      tick();
      start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         bcnt[d] = 0; didx[d] = -1; dcnt[d] = 0; rs[d] = '0; rc[d] = 1'b0; rv[d] = 1'b0;
         chk($sformatf("hold%0d", d), 32'(sum_w[d]), 32'(prev_sum[d]));
      end
      for (int k = 0; k < 11; k++) begin
         for (int d = 0; d < 3; d++) begin
            if (busy_w[d]) bcnt[d]++;
            if (done_w[d]) begin
               dcnt[d]++;
               if (didx[d] < 0) begin
                  didx[d] = k; rs[d] = sum_w[d]; rc[d] = cout_w[d]; rv[d] = ovf_w[d];
               end
            end
         end
         tick();
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("busy_len%0d %h%s%h", d, ta, ts ? "-" : "+", tb_), 32'(bcnt[d]), 32'(ns[d]));
         chk($sformatf("done_at%0d", d), 32'(didx[d]), 32'(ns[d]));
         chk($sformatf("done_cnt%0d", d), 32'(dcnt[d]), 32'd1);
         chk($sformatf("sum%0d %h%s%h", d, ta, ts ? "-" : "+", tb_), 32'(rs[d]), 32'(es));
         chk($sformatf("cout%0d %h%s%h", d, ta, ts ? "-" : "+", tb_), 32'(rc[d]), 32'(ec));
         chk($sformatf("ovf%0d %h%s%h", d, ta, ts ? "-" : "+", tb_), 32'(rv[d]), 32'(ev));
         prev_sum[d] = es;
      end
   endtask

   initial begin
      int         dc, gap;
      logic       seen;
      logic [7:0] hs, ra, rb, es;
      logic       hc, rcin, rsub, ec, ev;
      logic [8:0] full;

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      tick(); tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 32'd0);
         chk($sformatf("rst_done%0d", d), 32'(done_w[d]), 32'd0);
         chk($sformatf("rst_sum%0d", d),  32'(sum_w[d]),  32'd0);
         chk($sformatf("rst_cout%0d", d), 32'(cout_w[d]), 32'd0);
         chk($sformatf("rst_ovf%0d", d),  32'(ovf_w[d]),  32'd0);
         prev_sum[d] = '0;
      end
      rst_n = 1'b1;
      tick();

      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
      do_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      do_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      do_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // start held and operands changed during RUN: DIGIT=2 build must give one result
      a = 8'h0F; b = 8'h01; cin = 1'b1; sub = 1'b0; start = 1'b1;
      tick();
      a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b1;
      tick(); tick(); tick();
      start = 1'b0;
      dc = 0; hs = '0; hc = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (done_w[1]) begin dc++; hs = sum_w[1]; hc = cout_w[1]; end
         tick();
      end
      chk("held_done_cnt", 32'(dc), 32'd1);
      chk("held_sum", 32'(hs), 32'h11);
      chk("held_cout", 32'(hc), 32'd0);

      // back-to-back: new start in the DONE cycle
      a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!seen) begin
            if (done_w[1]) seen = 1'b1;
            else tick();
         end
      end
      chk("b2b_first_done", 32'(seen), 32'd1);
      chk("b2b_first_sum", 32'(sum_w[1]), 32'h03);
      a = 8'h10; b = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_busy_now", 32'(busy_w[1]), 32'd1);
      chk("b2b_sum_hold", 32'(sum_w[1]), 32'h03);
      gap = -1; hs = '0;
      for (int k = 1; k <= 10; k++) begin
         if (done_w[1] && gap < 0) begin gap = k; hs = sum_w[1]; end
         tick();
      end
      chk("b2b_gap", 32'(gap), 32'd5);
      chk("b2b_sum", 32'(hs), 32'h30);

      // reset at step 2 aborts; reset also overrides start
      a = 8'h33; b = 8'h44; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst_n = 1'b0; start = 1'b1;
      tick();
      chk("mid_rst_busy", 32'(busy_w[1]), 32'd0);
      chk("mid_rst_done", 32'(done_w[1]), 32'd0);
      chk("mid_rst_sum", 32'(sum_w[1]), 32'd0);
      chk("mid_rst_cout", 32'(cout_w[1]), 32'd0);
      tick();
      chk("rst_start_busy", 32'(busy_w), 32'd0);
      rst_n = 1'b1; start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done_w[1] || busy_w[1]) seen = 1'b1;
         tick();
      end
      chk("post_rst_quiet", 32'(seen), 32'd0);
      for (int d = 0; d < 3; d++) prev_sum[d] = '0;

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rcin = 1'($urandom_range(0, 1));
         rsub = 1'($urandom_range(0, 1));
         if (rsub) full = {1'b0, ra} - {1'b0, rb} + 9'h100;
         else      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rcin};
         es = full[7:0];
         ec = rsub ? (ra >= rb) : full[8];
         ev = rsub ? ((ra[7] != rb[7]) && (es[7] != ra[7]))
                   : ((ra[7] == rb[7]) && (es[7] != ra[7]));
         do_op(ra, rb, rcin, rsub, es, ec, ev);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
